// File: rtl/color_manager_pkg.sv
// Shared widths, FSM state codes, quadrant codes and command/notification tags for the VGA color manager.
package color_manager_pkg;

  localparam int UART_DATA_WIDTH           = 8;
  localparam int C_ADDR_WIDTH              = 2;
  localparam int C_DATA_WIDTH              = 8;
  localparam int CONFIG_STATUS_WIDTH       = 2;
  localparam int CONFIG_NOTIFICATION_WIDTH = 4;
  localparam int CONFIG_ERROR_WIDTH        = 2;
  localparam int VGA_NOTIFICATION_WIDTH    = 4;
  localparam int DATA_WIDTH                = 8;
  localparam int H_CNT_WIDTH               = 12;
  localparam int V_CNT_WIDTH               = 11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_DATA = 2'd1;
  localparam logic [1:0] ST_WRITE     = 2'd2;

  localparam logic [1:0] Q_LU = 2'b00;
  localparam logic [1:0] Q_RU = 2'b01;
  localparam logic [1:0] Q_LD = 2'b10;
  localparam logic [1:0] Q_RD = 2'b11;

  localparam logic [3:0] HEADER_TAG     = 4'b1010;
  localparam logic [1:0] NOTIF_TAG      = 2'b01;
  localparam logic [1:0] ERR_BAD_HEADER = 2'b01;
  localparam logic [1:0] ERR_BUSY       = 2'b10;

  function automatic logic is_header(input logic [UART_DATA_WIDTH-1:0] b);
    return (b[7:6] == 2'b00) && (b[3:0] == HEADER_TAG);
  endfunction

endpackage

// File: rtl/vga_color_manager_if.sv
// Config-memory write bus: the color manager is master, the config memory is slave.
interface vga_color_manager_if;
  import color_manager_pkg::*;

  logic [C_ADDR_WIDTH-1:0] C_Addr;
  logic [C_DATA_WIDTH-1:0] C_Data;
  logic                    C_Valid;
  logic                    C_Rdy;

  modport master (output C_Addr, output C_Data, output C_Valid, input C_Rdy);
  modport slave  (input C_Addr, input C_Data, input C_Valid, output C_Rdy);
endinterface

// File: rtl/vga_position_tracker.sv
// Tracks screen position from HSync/VSync rising edges; flags right/bottom halves.
// With CM_DEBUG_PATTERN_EN defined it also exports the h^v test-pattern byte.
module vga_position_tracker
  import color_manager_pkg::*;
#(
  parameter int H_HALF = 320,
  parameter int V_HALF = 240
) (
  input  logic Clk,
  input  logic Rst,
  input  logic HSync,
  input  logic VSync,
  output logic right,
  output logic bottom
`ifdef CM_DEBUG_PATTERN_EN
  ,
  output logic [DATA_WIDTH-1:0] pattern
`endif
);

  logic                   hs_d, vs_d;
  logic                   h_rise, v_rise;
  logic [H_CNT_WIDTH-1:0] h_cnt;
  logic [V_CNT_WIDTH-1:0] v_cnt;

  assign h_rise = HSync & ~hs_d;
  assign v_rise = VSync & ~vs_d;

  // Both counters saturate so a missing sync never wraps back into the top-left quadrant.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      hs_d <= HSync;
      vs_d <= VSync;
      if (h_rise)
        h_cnt <= '0;
      else if (h_cnt != '1)
        h_cnt <= h_cnt + 1'b1;
      if (v_rise)
        v_cnt <= '0;
      else if (h_rise && (v_cnt != '1))
        v_cnt <= v_cnt + 1'b1;
    end
  end

  assign right  = (h_cnt >= H_CNT_WIDTH'(H_HALF));
  assign bottom = (v_cnt >= V_CNT_WIDTH'(V_HALF));

`ifdef CM_DEBUG_PATTERN_EN
  assign pattern = h_cnt[7:0] ^ v_cnt[7:0];
`endif

endmodule

// File: rtl/vga_color_manager.sv
// Decodes UART color commands into config-memory writes and drives the split-screen pixel color.
// Optional feature macro: CM_DEBUG_PATTERN_EN (VGA_Debugg selects an h^v test pattern).
module vga_color_manager
  import color_manager_pkg::*;
#(
  parameter int H_HALF = 320,
  parameter int V_HALF = 240
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic                                 Empty,
  input  logic [UART_DATA_WIDTH-1:0]           RXD_Data,
  vga_color_manager_if.master                  cfg,
  input  logic                                 Vertical_Split,
  input  logic                                 Horizontal_Split,
  input  logic                                 VGA_Debugg,
  input  logic                                 HSync,
  input  logic                                 VSync,
  output logic [DATA_WIDTH-1:0]                Data_VGA,
  output logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
  output logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  output logic                                 Config_Notification_Valid,
  output logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  output logic                                 Error_Valid,
  output logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  output logic                                 VGA_Notification_Valid
);

  logic [1:0]              state;
  logic [C_ADDR_WIDTH-1:0] quad;
  logic [C_DATA_WIDTH-1:0] data;
  logic [C_DATA_WIDTH-1:0] color [4];
  logic                    byte_vld;
  logic                    right, bottom;
  logic [1:0]              sel;
  logic [3:0]              vga_mode;
  logic                    primed;
`ifdef CM_DEBUG_PATTERN_EN
  logic [DATA_WIDTH-1:0]   pattern;
`endif

  vga_position_tracker #(.H_HALF(H_HALF), .V_HALF(V_HALF)) u_pos (
    .Clk    (Clk),
    .Rst    (Rst),
    .HSync  (HSync),
    .VSync  (VSync),
    .right  (right),
    .bottom (bottom)
`ifdef CM_DEBUG_PATTERN_EN
    ,
    .pattern(pattern)
`endif
  );

  assign byte_vld      = ~Empty;
  assign cfg.C_Valid   = (state == ST_WRITE);
  assign cfg.C_Addr    = quad;
  assign cfg.C_Data    = data;
  assign Config_Status = state;

  // Command FSM; a byte arriving while a write is pending is dropped and flagged.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state                     <= ST_IDLE;
      quad                      <= '0;
      data                      <= '0;
      for (int i = 0; i < 4; i++) color[i] <= '0;
      Config_Notification       <= '0;
      Config_Notification_Valid <= 1'b0;
      Config_Error              <= '0;
      Error_Valid               <= 1'b0;
    end else begin
      Config_Notification_Valid <= 1'b0;
      Error_Valid               <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (byte_vld) begin
            if (is_header(RXD_Data)) begin
              quad  <= RXD_Data[5:4];
              state <= ST_WAIT_DATA;
            end else begin
              Config_Error <= ERR_BAD_HEADER;
              Error_Valid  <= 1'b1;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (byte_vld) begin
            data  <= RXD_Data;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (byte_vld) begin
            Config_Error <= ERR_BUSY;
            Error_Valid  <= 1'b1;
          end
          if (cfg.C_Rdy) begin
            color[quad]               <= data;
            Config_Notification       <= {NOTIF_TAG, quad};
            Config_Notification_Valid <= 1'b1;
            state                     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sel = Q_LU;
    case ({Vertical_Split, Horizontal_Split})
      2'b10:   sel = right  ? Q_RU : Q_LU;
      2'b01:   sel = bottom ? Q_LD : Q_LU;
      2'b11:   sel = {bottom, right};
      default: sel = Q_LU;
    endcase
  end

  assign vga_mode = {1'b0, VGA_Debugg, Vertical_Split, Horizontal_Split};

  // The first cycle after reset only captures the mode so no spurious notification fires.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Data_VGA               <= '0;
      VGA_Notification       <= '0;
      VGA_Notification_Valid <= 1'b0;
      primed                 <= 1'b0;
    end else begin
`ifdef CM_DEBUG_PATTERN_EN
      if (VGA_Debugg)
        Data_VGA <= pattern;
      else
        Data_VGA <= color[sel];
`else
      Data_VGA <= color[sel];
`endif
      VGA_Notification_Valid <= 1'b0;
      primed                 <= 1'b1;
      if (!primed) begin
        VGA_Notification <= vga_mode;
      end else if (vga_mode != VGA_Notification) begin
        VGA_Notification       <= vga_mode;
        VGA_Notification_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_color_manager.sv
// Self-checking bench for vga_color_manager: randomized commands and screen positions against a reference model.
module tb_vga_color_manager;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Empty;
  logic [7:0] RXD_Data;
  logic       Vertical_Split, Horizontal_Split, VGA_Debugg;
  logic       HSync, VSync;
  logic [7:0] Data_VGA;
  logic [1:0] Config_Status;
  logic [3:0] Config_Notification;
  logic       Config_Notification_Valid;
  logic [1:0] Config_Error;
  logic       Error_Valid;
  logic [3:0] VGA_Notification;
  logic       VGA_Notification_Valid;

  vga_color_manager_if cif();

  vga_color_manager dut (
    .Clk                      (Clk),
    .Rst                      (Rst),
    .Empty                    (Empty),
    .RXD_Data                 (RXD_Data),
    .cfg                      (cif),
    .Vertical_Split           (Vertical_Split),
    .Horizontal_Split         (Horizontal_Split),
    .VGA_Debugg               (VGA_Debugg),
    .HSync                    (HSync),
    .VSync                    (VSync),
    .Data_VGA                 (Data_VGA),
    .Config_Status            (Config_Status),
    .Config_Notification      (Config_Notification),
    .Config_Notification_Valid(Config_Notification_Valid),
    .Config_Error             (Config_Error),
    .Error_Valid              (Error_Valid),
    .VGA_Notification         (VGA_Notification),
    .VGA_Notification_Valid   (VGA_Notification_Valid)
  );

  always #5 Clk = ~Clk;

  int         total = 0;
  int         bad   = 0;
  int         exp_h, exp_v;
  logic       hs_prev, vs_prev;
  logic [7:0] mcolor [4];
  logic [7:0] exp_pix;

  // Screen colour from the position and split mode: index 0 LU, 1 RU, 2 LD, 3 RD.
  function automatic logic [7:0] ref_pixel(input int h, input int v, input logic vm, input logic hm);
    bit r, b;
    r = (h >= 320);
    b = (v >= 240);
`ifdef CM_DEBUG_PATTERN_EN
    if (VGA_Debugg) return 8'(h ^ v);
`endif
    if (!vm && !hm) return mcolor[0];
    if (vm && !hm)  return r ? mcolor[1] : mcolor[0];
    if (!vm && hm)  return b ? mcolor[2] : mcolor[0];
    if (b)          return r ? mcolor[3] : mcolor[2];
    return r ? mcolor[1] : mcolor[0];
  endfunction

  task automatic cyc();
    @(posedge Clk);
    if (!Rst) begin
      exp_h = 0; exp_v = 0; hs_prev = 1'b0; vs_prev = 1'b0; exp_pix = 8'h00;
    end else begin
      exp_pix = ref_pixel(exp_h, exp_v, Vertical_Split, Horizontal_Split);
      if (VSync && !vs_prev)                        exp_v = 0;
      else if (HSync && !hs_prev && exp_v < 2047)   exp_v = exp_v + 1;
      if (HSync && !hs_prev)                        exp_h = 0;
      else if (exp_h < 4095)                        exp_h = exp_h + 1;
      hs_prev = HSync;
      vs_prev = VSync;
    end
    @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    Empty = 1'b0; RXD_Data = b;
    cyc();
    Empty = 1'b1;
  endtask

  task automatic goto(input int h, input int v);
    HSync = 1'b1; VSync = 1'b1; cyc();
    HSync = 1'b0; VSync = 1'b0; cyc();
    for (int i = 0; i < v; i++) begin
      HSync = 1'b1; cyc();
      HSync = 1'b0; cyc();
    end
    for (int i = 0; i < 5000 && exp_h < h; i++) cyc();
  endtask

  task automatic do_write(input logic [1:0] q, input logic [7:0] d, input int hold);
    cif.C_Rdy = (hold == 0);
    send_byte({2'b00, q, 4'b1010});
    total++; if (Config_Status !== 2'd1) begin bad++; $display("FAIL status_wait got=%0d want=1", Config_Status); end
    send_byte(d);
    total++; if (Config_Status !== 2'd2) begin bad++; $display("FAIL status_write got=%0d want=2", Config_Status); end
    total++; if ({cif.C_Valid, cif.C_Addr, cif.C_Data} !== {1'b1, q, d}) begin bad++;
      $display("FAIL write_req got=%b/%0d/%h want=1/%0d/%h", cif.C_Valid, cif.C_Addr, cif.C_Data, q, d); end
    for (int i = 0; i < hold; i++) begin
      cyc();
      total++; if ({Config_Status, cif.C_Valid, cif.C_Addr, cif.C_Data} !== {2'd2, 1'b1, q, d}) begin bad++;
        $display("FAIL write_hold cyc=%0d got=%0d/%b/%0d/%h want=2/1/%0d/%h", i, Config_Status, cif.C_Valid, cif.C_Addr, cif.C_Data, q, d); end
    end
    cif.C_Rdy = 1'b1;
    cyc();
    mcolor[q] = d;
    total++; if ({Config_Status, cif.C_Valid} !== {2'd0, 1'b0}) begin bad++;
      $display("FAIL accept got=%0d/%b want=0/0", Config_Status, cif.C_Valid); end
    total++; if ({Config_Notification_Valid, Config_Notification} !== {1'b1, 2'b01, q}) begin bad++;
      $display("FAIL notif got=%b/%b want=1/%b", Config_Notification_Valid, Config_Notification, {2'b01, q}); end
    cyc();
    total++; if (Config_Notification_Valid !== 1'b0) begin bad++; $display("FAIL notif_pulse got=%b want=0", Config_Notification_Valid); end
  endtask

  task automatic test_reset();
    Rst = 1'b0; Empty = 1'b1; RXD_Data = 8'h00; cif.C_Rdy = 1'b0;
    Vertical_Split = 1'b0; Horizontal_Split = 1'b0; VGA_Debugg = 1'b0; HSync = 1'b0; VSync = 1'b0;
    for (int i = 0; i < 4; i++) mcolor[i] = 8'h00;
    cyc(); cyc();
    total++; if ({Data_VGA, Config_Status, cif.C_Valid, cif.C_Addr, cif.C_Data} !== 21'd0) begin bad++;
      $display("FAIL reset_data got=%h/%0d/%b/%0d/%h want=0", Data_VGA, Config_Status, cif.C_Valid, cif.C_Addr, cif.C_Data); end
    total++; if ({Config_Notification, Config_Notification_Valid, Config_Error, Error_Valid, VGA_Notification, VGA_Notification_Valid} !== 13'd0) begin bad++;
      $display("FAIL reset_flags got=%h/%b/%h/%b/%h/%b want=0", Config_Notification, Config_Notification_Valid, Config_Error, Error_Valid, VGA_Notification, VGA_Notification_Valid); end
    Rst = 1'b1;
    cyc(); cyc();
    total++; if (VGA_Notification_Valid !== 1'b0) begin bad++; $display("FAIL reset_vga_notif got=%b want=0", VGA_Notification_Valid); end
  endtask

  task automatic test_basic_write();
    total++; if (Config_Status !== 2'd0) begin bad++; $display("FAIL status_idle got=%0d want=0", Config_Status); end
    do_write(2'b00, 8'h5A, 0);
  endtask

  task automatic test_quadrants();
    do_write(2'b01, 8'h5F, 0);
    do_write(2'b11, 8'h50, 2);
    do_write(2'b10, 8'h00, 10);
    Vertical_Split = 1'b1; Horizontal_Split = 1'b1;
    cyc(); cyc();
    goto(10, 10);   total++; if (Data_VGA !== 8'h5A) begin bad++; $display("FAIL quad_lu got=%h want=5a", Data_VGA); end
    goto(400, 10);  total++; if (Data_VGA !== 8'h5F) begin bad++; $display("FAIL quad_ru got=%h want=5f", Data_VGA); end
    goto(10, 300);  total++; if (Data_VGA !== 8'h00) begin bad++; $display("FAIL quad_ld got=%h want=00", Data_VGA); end
    goto(400, 300); total++; if (Data_VGA !== 8'h50) begin bad++; $display("FAIL quad_rd got=%h want=50", Data_VGA); end
  endtask

  task automatic test_boundaries();
    Vertical_Split = 1'b1; Horizontal_Split = 1'b0;
    goto(315, 20);
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++; if (Data_VGA !== exp_pix) begin bad++; $display("FAIL h_edge h=%0d got=%h want=%h", exp_h, Data_VGA, exp_pix); end
    end
    Vertical_Split = 1'b0; Horizontal_Split = 1'b1;
    for (int v = 238; v <= 242; v++) begin
      goto(100, v);
      total++; if (Data_VGA !== exp_pix) begin bad++; $display("FAIL v_edge v=%0d got=%h want=%h", v, Data_VGA, exp_pix); end
    end
  endtask

  task automatic test_saturation();
    Vertical_Split = 1'b1; Horizontal_Split = 1'b1;
    goto(0, 250);
    for (int i = 0; i < 4200; i++) cyc();
    total++; if (Data_VGA !== mcolor[3]) begin bad++; $display("FAIL h_sat got=%h want=%h", Data_VGA, mcolor[3]); end
    goto(5, 2100);
    total++; if (Data_VGA !== mcolor[2]) begin bad++; $display("FAIL v_sat got=%h want=%h", Data_VGA, mcolor[2]); end
  endtask

  task automatic test_bad_header();
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = (i == 0) ? 8'h0B : 8'($urandom);
      if (b[7:6] == 2'b00 && b[3:0] == 4'b1010) b[0] = 1'b1;
      send_byte(b);
      total++; if ({Error_Valid, Config_Error, Config_Status} !== {1'b1, 2'b01, 2'd0}) begin bad++;
        $display("FAIL bad_hdr %h got=%b/%b/%0d want=1/01/0", b, Error_Valid, Config_Error, Config_Status); end
      cyc();
      total++; if (Error_Valid !== 1'b0) begin bad++; $display("FAIL bad_hdr_pulse got=%b want=0", Error_Valid); end
    end
  endtask

  task automatic test_write_drop();
    logic [7:0] d;
    d = 8'($urandom);
    cif.C_Rdy = 1'b0;
    send_byte(8'h1A);
    send_byte(d);
    send_byte(8'h33);
    total++; if ({Error_Valid, Config_Error} !== 3'b110) begin bad++; $display("FAIL drop_err got=%b/%b want=1/10", Error_Valid, Config_Error); end
    total++; if ({Config_Status, cif.C_Valid, cif.C_Addr, cif.C_Data} !== {2'd2, 1'b1, 2'b01, d}) begin bad++;
      $display("FAIL drop_hold got=%0d/%b/%0d/%h want=2/1/1/%h", Config_Status, cif.C_Valid, cif.C_Addr, cif.C_Data, d); end
    cif.C_Rdy = 1'b1;
    cyc();
    mcolor[1] = d;
    total++; if ({Config_Notification_Valid, Config_Notification} !== 5'b10101) begin bad++;
      $display("FAIL drop_notif got=%b/%b want=1/0101", Config_Notification_Valid, Config_Notification); end
    Vertical_Split = 1'b1; Horizontal_Split = 1'b0;
    goto(500, 5);
    total++; if (Data_VGA !== d) begin bad++; $display("FAIL drop_color got=%h want=%h", Data_VGA, d); end
  endtask

  task automatic test_random();
    int h, v;
    for (int i = 0; i < 6; i++)
      do_write(2'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    for (int i = 0; i < 8; i++) begin
      Vertical_Split = 1'($urandom); Horizontal_Split = 1'($urandom);
      h = int'($urandom_range(0, 639)); v = int'($urandom_range(0, 300));
      goto(h, v);
      total++; if (Data_VGA !== exp_pix) begin bad++;
        $display("FAIL rand_pix h=%0d v=%0d mode=%b%b got=%h want=%h", exp_h, exp_v, Vertical_Split, Horizontal_Split, Data_VGA, exp_pix); end
    end
  endtask

  task automatic test_vga_notif();
    Vertical_Split = 1'b0; Horizontal_Split = 1'b0; VGA_Debugg = 1'b0;
    cyc(); cyc();
    Vertical_Split = 1'b1;
    cyc();
    total++; if ({VGA_Notification_Valid, VGA_Notification} !== 5'b10010) begin bad++;
      $display("FAIL vga_notif got=%b/%b want=1/0010", VGA_Notification_Valid, VGA_Notification); end
    cyc();
    total++; if ({VGA_Notification_Valid, VGA_Notification} !== 5'b00010) begin bad++;
      $display("FAIL vga_notif_pulse got=%b/%b want=0/0010", VGA_Notification_Valid, VGA_Notification); end
    VGA_Debugg = 1'b1;
    cyc();
    total++; if ({VGA_Notification_Valid, VGA_Notification} !== 5'b10110) begin bad++;
      $display("FAIL vga_dbg got=%b/%b want=1/0110", VGA_Notification_Valid, VGA_Notification); end
    goto(330, 7);
    total++; if (Data_VGA !== exp_pix) begin bad++; $display("FAIL dbg_pix got=%h want=%h", Data_VGA, exp_pix); end
    VGA_Debugg = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_reset_midtransfer();
    cif.C_Rdy = 1'b0;
    send_byte(8'h3A);
    send_byte(8'hAA);
    Rst = 1'b0;
    #1;
    total++; if ({Config_Status, cif.C_Valid} !== 3'b000) begin bad++; $display("FAIL rst_abort got=%0d/%b want=0/0", Config_Status, cif.C_Valid); end
    cyc();
    Rst = 1'b1; cif.C_Rdy = 1'b1;
    for (int i = 0; i < 4; i++) mcolor[i] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if ({Config_Notification_Valid, cif.C_Valid} !== 2'b00) begin bad++;
        $display("FAIL rst_no_notif got=%b/%b want=0/0", Config_Notification_Valid, cif.C_Valid); end
    end
    Vertical_Split = 1'b1; Horizontal_Split = 1'b1;
    goto(400, 300);
    total++; if (Data_VGA !== 8'h00) begin bad++; $display("FAIL rst_colors got=%h want=00", Data_VGA); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_quadrants();
    test_boundaries();
    test_saturation();
    test_bad_header();
    test_write_drop();
    test_random();
    test_vga_notif();
    test_reset_midtransfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
